// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: stall/flush controller for load-use, memory wait, taken-branch squash and HALT.
// Optional stall statistics counter is built only when HAZARD_STATS_EN is defined.
module hazard_stall_unit #(
    parameter int FLUSH_CYCLES = 1,
    parameter int WAIT_LIMIT   = 64,
    parameter int STAT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        rs_d,
    input  logic [2:0]        rt_d,
    input  logic              rs_valid_d,
    input  logic              rt_valid_d,
    input  logic [2:0]        rd_e,
    input  logic              reg_write_ex,
    input  logic              mem_read_ex,
    input  logic              branch_taken_ex,
    input  logic              mem_busy,
    input  logic              halt_d,
    output logic              stall_pc,
    output logic              stall_fd,
    output logic              stall_ex,
    output logic              bubble_de,
    output logic              flush_fd,
    output logic              err_timeout,
    output logic [1:0]        state_o,
    output logic [STAT_W-1:0] stall_cycles
);
    typedef enum logic [1:0] {RUN, MEMWAIT, FLUSH, HALTED} state_t;
    localparam int WW = $clog2(WAIT_LIMIT + 1);

    state_t        state_q, state_d, eff;
    logic [2:0]    cnt_q, cnt_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          err_q, hit, load_use;

    always_comb begin
        load_use  = mem_read_ex & reg_write_ex &
                    ((rs_valid_d & (rs_d == rd_e)) | (rt_valid_d & (rt_d == rd_e)));
        // leaving a memory wait resumes whatever flush was frozen by it
        eff       = (state_q == MEMWAIT) ? ((cnt_q != 3'd0) ? FLUSH : RUN) : state_q;
        stall_pc  = 1'b0;
        stall_fd  = 1'b0;
        stall_ex  = 1'b0;
        bubble_de = 1'b0;
        flush_fd  = 1'b0;
        state_d   = RUN;
        cnt_d     = cnt_q;
        wait_d    = '0;
        hit       = 1'b0;
        if (state_q == HALTED) begin
            stall_pc = 1'b1;
            state_d  = HALTED;
        end else if (mem_busy) begin
            stall_pc = 1'b1;
            stall_fd = 1'b1;
            stall_ex = 1'b1;
            state_d  = MEMWAIT;
            wait_d   = (wait_q == WW'(WAIT_LIMIT)) ? wait_q : wait_q + 1'b1;
            hit      = (wait_d == WW'(WAIT_LIMIT));
        end else if (branch_taken_ex || eff == FLUSH) begin
            flush_fd  = 1'b1;
            bubble_de = 1'b1;
            cnt_d     = branch_taken_ex ? 3'(FLUSH_CYCLES - 1) : cnt_q - 3'd1;
            state_d   = (cnt_d != 3'd0) ? FLUSH : RUN;
        end else if (halt_d) begin
            stall_pc = 1'b1;
            state_d  = HALTED;
        end else if (load_use) begin
            stall_pc  = 1'b1;
            stall_fd  = 1'b1;
            bubble_de = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            err_q   <= err_q | hit;
        end
    end

    assign err_timeout = err_q | hit;
    assign state_o     = state_q;

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] stat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stat_q <= '0;
        else if (stall_pc && state_q != HALTED && stat_q != '1)
            stat_q <= stat_q + 1'b1;
    end

    assign stall_cycles = stat_q;
`else
    assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: scoreboard bench; expected output vectors queued at drive time, popped at sample time.
module tb_hazard_stall_unit;
`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic [2:0] rs_d, rt_d, rd_e;
    logic rs_valid_d, rt_valid_d, reg_write_ex, mem_read_ex, branch_taken_ex, mem_busy, halt_d;
    logic stall_pc, stall_fd, stall_ex, bubble_de, flush_fd, err_timeout;
    logic [1:0] state_o;
    logic [15:0] stall_cycles;
    logic [7:0] outs, e;
    logic [7:0] sb[$];
    logic [15:0] stat_m;
    int n_vec = 0, n_bad = 0;

    hazard_stall_unit #(.FLUSH_CYCLES(2), .WAIT_LIMIT(64), .STAT_W(16)) dut (
        .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d), .rs_valid_d(rs_valid_d),
        .rt_valid_d(rt_valid_d), .rd_e(rd_e), .reg_write_ex(reg_write_ex),
        .mem_read_ex(mem_read_ex), .branch_taken_ex(branch_taken_ex), .mem_busy(mem_busy),
        .halt_d(halt_d), .stall_pc(stall_pc), .stall_fd(stall_fd), .stall_ex(stall_ex),
        .bubble_de(bubble_de), .flush_fd(flush_fd), .err_timeout(err_timeout),
        .state_o(state_o), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;
    assign outs = {stall_pc, stall_fd, stall_ex, bubble_de, flush_fd, err_timeout, state_o};

    // {rs, rt, rs_valid, rt_valid, rd, reg_write, mem_read, branch, busy, halt}
    task automatic drive(input logic [16:0] v, input logic [7:0] exp_o);
        {rs_d, rt_d, rs_valid_d, rt_valid_d, rd_e, reg_write_ex, mem_read_ex,
         branch_taken_ex, mem_busy, halt_d} = v;
        sb.push_back(exp_o);
    endtask

    task automatic count_stat(input logic [7:0] x);
        if (x[7] && x[1:0] != 2'd3 && stat_m != 16'hFFFF) stat_m++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(17'h0, 8'h00);
        #2;
        e = sb.pop_front();
        n_vec++;
        if (outs !== e) begin n_bad++; $display("FAIL reset_outs: got %h exp %h", outs, e); end
        n_vec++;
        if (stall_cycles !== 16'd0) begin n_bad++; $display("FAIL reset_stats: got %0d exp 0", stall_cycles); end
        stat_m = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load_use;
        logic [16:0] v[6];
        logic [7:0]  x[6];
        // load r3 / ADD r3,r2 ; load advanced ; ADDI with rt=3 not read ; R0 match ; no write ; back-to-back
        v = '{{3'd3, 3'd2, 2'b11, 3'd3, 5'b11000}, {3'd3, 3'd2, 2'b11, 3'd1, 5'b10000},
              {3'd2, 3'd3, 2'b10, 3'd3, 5'b11000}, {3'd0, 3'd5, 2'b10, 3'd0, 5'b11000},
              {3'd3, 3'd3, 2'b11, 3'd3, 5'b01000}, {3'd4, 3'd6, 2'b01, 3'd6, 5'b11000}};
        x = '{8'hD0, 8'h00, 8'h00, 8'hD0, 8'h00, 8'hD0};
        for (int i = 0; i < 6; i++) begin
            drive(v[i], x[i]);
            #2;
            e = sb.pop_front();
            n_vec++;
            if (outs !== e) begin n_bad++; $display("FAIL load_use[%0d]: got %h exp %h", i, outs, e); end
            count_stat(e);
            @(negedge clk);
        end
        for (int i = 0; i < 24; i++) begin
            logic [2:0] a, b, d;
            logic av, bv, w, m, lu;
            a = 3'($urandom_range(0, 3)); b = 3'($urandom_range(0, 3)); d = 3'($urandom_range(0, 3));
            {av, bv, w, m} = 4'($urandom);
            lu = m & w & ((av & (a == d)) | (bv & (b == d)));
            drive({a, b, av, bv, d, w, m, 3'b000}, lu ? 8'hD0 : 8'h00);
            #2;
            e = sb.pop_front();
            n_vec++;
            if (outs !== e) begin n_bad++; $display("FAIL load_use_rand[%0d]: got %h exp %h", i, outs, e); end
            count_stat(e);
            @(negedge clk);
        end
    endtask

    task automatic test_flush;
        logic [16:0] lu_br, lu;
        lu_br = {3'd3, 3'd2, 2'b11, 3'd3, 5'b11100};
        lu    = {3'd3, 3'd2, 2'b11, 3'd3, 5'b11000};
        for (int i = 0; i < 3; i++) begin
            drive(i == 0 ? lu_br : (i == 1 ? lu : 17'h0), i == 0 ? 8'h18 : (i == 1 ? 8'h1A : 8'h00));
            #2;
            e = sb.pop_front();
            n_vec++;
            if (outs !== e) begin n_bad++; $display("FAIL flush[%0d]: got %h exp %h", i, outs, e); end
            count_stat(e);
            @(negedge clk);
        end
    endtask

    task automatic test_mem_in_flush;
        logic [16:0] v[6];
        logic [7:0]  x[6];
        v = '{17'h00004, 17'h00002, 17'h00002, 17'h00002, 17'h0, 17'h0};
        x = '{8'h18, 8'hE2, 8'hE1, 8'hE1, 8'h19, 8'h00};
        for (int i = 0; i < 6; i++) begin
            drive(v[i], x[i]);
            #2;
            e = sb.pop_front();
            n_vec++;
            if (outs !== e) begin n_bad++; $display("FAIL mem_in_flush[%0d]: got %h exp %h", i, outs, e); end
            count_stat(e);
            @(negedge clk);
        end
        n_vec++;
        if (stall_cycles !== (STATS ? stat_m : 16'd0)) begin
            n_bad++; $display("FAIL stats_count: got %0d exp %0d", stall_cycles, STATS ? stat_m : 16'd0);
        end
    endtask

    task automatic test_timeout;
        for (int i = 1; i <= 66; i++) begin
            drive(17'h00002, (i == 1 ? 8'hE0 : 8'hE1) | (i >= 64 ? 8'h04 : 8'h00));
            #2;
            e = sb.pop_front();
            n_vec++;
            if (outs !== e) begin n_bad++; $display("FAIL timeout[%0d]: got %h exp %h", i, outs, e); end
            count_stat(e);
            @(negedge clk);
        end
        #1;
        drive(17'h00002, 8'hE1 | 8'h04);
        rst = 1'b1;
        mem_busy = 1'b0;
        sb.delete();
        sb.push_back(8'h00);
        #1;
        e = sb.pop_front();
        n_vec++;
        if (outs !== e) begin n_bad++; $display("FAIL rst_mid_wait: got %h exp %h", outs, e); end
        stat_m = 0;
        @(negedge clk);
        rst = 1'b0;
        drive(17'h0, 8'h00);
        #2;
        e = sb.pop_front();
        n_vec++;
        if (outs !== e) begin n_bad++; $display("FAIL after_rst_wait: got %h exp %h", outs, e); end
        @(negedge clk);
    endtask

    task automatic test_halt;
        drive({12'h0, 5'b00001}, 8'h80);
        #2;
        e = sb.pop_front();
        n_vec++;
        if (outs !== e) begin n_bad++; $display("FAIL halt_entry: got %h exp %h", outs, e); end
        count_stat(e);
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            drive(17'($urandom), 8'h83);
            #2;
            e = sb.pop_front();
            n_vec++;
            if (outs !== e) begin n_bad++; $display("FAIL halted[%0d]: got %h exp %h", i, outs, e); end
            count_stat(e);
            @(negedge clk);
        end
        n_vec++;
        if (stall_cycles !== (STATS ? stat_m : 16'd0)) begin
            n_bad++; $display("FAIL halt_stats: got %0d exp %0d", stall_cycles, STATS ? stat_m : 16'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stat_m = 0;
        drive(17'h0, 8'h00);
        #2;
        e = sb.pop_front();
        n_vec++;
        if (outs !== e) begin n_bad++; $display("FAIL halt_release: got %h exp %h", outs, e); end
        @(negedge clk);
    endtask

    initial begin
        {rs_d, rt_d, rs_valid_d, rt_valid_d, rd_e, reg_write_ex, mem_read_ex,
         branch_taken_ex, mem_busy, halt_d} = '0;
        stat_m = 0;
        @(negedge clk);
        test_reset;
        test_load_use;
        test_flush;
        test_mem_in_flush;
        test_timeout;
        test_halt;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end
endmodule
